// File: rtl/ex_multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_multicycle_ctrl_if
// Groups the execute-stage signals exchanged between the pipeline and the
// multi-cycle ALU sequencer.
//
// Signals (driven by the pipeline = master):
//   validE      E stage holds a real instruction
//   alucontrolE ALU opcode in E
//   srcA, srcB  operands
//   flushE      E-stage flush
// Signals (driven by the sequencer = slave):
//   stall       hold PC, IF/ID, ID/EX (combinational)
//   busy        registered, high while iterating
//   done        registered one-cycle result-valid pulse
//   mc_sel      selects result over aluresultE (combinational)
//   result      registered multi-cycle result
// ---------------------------------------------------------------------------
interface ex_multicycle_ctrl_if #(
    parameter int WIDTH = 19
);
    logic             validE;
    logic [4:0]       alucontrolE;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             flushE;
    logic             stall;
    logic             busy;
    logic             done;
    logic             mc_sel;
    logic [WIDTH-1:0] result;

    modport master (
        output validE, alucontrolE, srcA, srcB, flushE,
        input  stall, busy, done, mc_sel, result
    );

    modport slave (
        input  validE, alucontrolE, srcA, srcB, flushE,
        output stall, busy, done, mc_sel, result
    );
endinterface

// File: rtl/ex_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// ex_multicycle_ctrl
// Execute-stage sequencer for MUL / MULH / DIV / REM. Captures the operands
// when a multi-cycle opcode enters E, runs a WIDTH-step shift-add multiplier
// or restoring divider, stalls the front of the pipeline meanwhile, and
// presents the result for one cycle (DONE) for the E->M register.
//
// Ports:
//   clk  clock
//   rst  synchronous, active-low reset
//   bus  ex_multicycle_ctrl_if.slave (validE, alucontrolE, srcA, srcB,
//        flushE in; stall, busy, done, mc_sel, result out)
//
// Optional feature: define MULH_EN to decode OP_MULH as a multi-cycle op
// returning the high half of the product.
// ---------------------------------------------------------------------------
module ex_multicycle_ctrl #(
    parameter int         WIDTH   = 19,
    parameter logic [4:0] OP_MUL  = 5'b01010,
    parameter logic [4:0] OP_DIV  = 5'b01011,
    parameter logic [4:0] OP_REM  = 5'b01100,
    parameter logic [4:0] OP_MULH = 5'b01101
) (
    input logic                 clk,
    input logic                 rst,
    ex_multicycle_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, done_q;

    logic               isMc;
    logic               start;
    logic               divZero;
    logic               opIsDiv;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     remShift;
    logic [WIDTH+1:0]   divDiff;
    logic [2*WIDTH-1:0] stepAcc;
    logic [WIDTH-1:0]   stepA;
    logic [WIDTH-1:0]   stepResult;

    // Decode which opcodes this block takes over from the combinational ALU.
    always_comb begin
        isMc = (bus.alucontrolE == OP_MUL) || (bus.alucontrolE == OP_DIV) ||
               (bus.alucontrolE == OP_REM);
`ifdef MULH_EN
        isMc = isMc || (bus.alucontrolE == OP_MULH);
`else
        isMc = isMc;
`endif
        start   = (state_q == IDLE) && bus.validE && isMc && !bus.flushE;
        divZero = ((bus.alucontrolE == OP_DIV) || (bus.alucontrolE == OP_REM)) &&
                  (bus.srcB == '0);
    end

    // One iteration of either algorithm. The accumulator's upper half holds
    // the running product high part / partial remainder, the lower half
    // collects product low bits / quotient bits. a_q is consumed one bit per
    // step: LSB-first for multiply, MSB-first for divide.
    always_comb begin
        opIsDiv  = (op_q == OP_DIV) || (op_q == OP_REM);
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        remShift = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        divDiff  = {1'b0, remShift} - {2'b00, b_q};
        stepAcc  = acc_q;
        stepA    = a_q;
        if (opIsDiv) begin
            // Restoring step: keep the trial difference only if it did not borrow.
            if (!divDiff[WIDTH+1]) begin
                stepAcc = {divDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                stepAcc = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            stepA = {a_q[WIDTH-2:0], 1'b0};
        end else begin
            if (a_q[0]) begin
                stepAcc = {mulSum, acc_q[WIDTH-1:1]};
            end else begin
                stepAcc = {1'b0, acc_q[2*WIDTH-1:1]};
            end
            stepA = {1'b0, a_q[WIDTH-1:1]};
        end
        // op_q only ever holds OP_MULH when the decode accepted it.
        if ((op_q == OP_REM) || (op_q == OP_MULH)) begin
            stepResult = stepAcc[2*WIDTH-1:WIDTH];
        end else begin
            stepResult = stepAcc[WIDTH-1:0];
        end
    end

    // Next-state and datapath-load logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = bus.srcA;
                    b_d   = bus.srcB;
                    op_d  = bus.alucontrolE;
                    acc_d = '0;
                    cnt_d = '0;
                    if (divZero) begin
                        // Divide by zero resolves immediately without iterating.
                        result_d = (bus.alucontrolE == OP_DIV) ? '1 : bus.srcA;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus.flushE) begin
                    state_d = IDLE;
                end else begin
                    acc_d = stepAcc;
                    a_d   = stepA;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) begin
                        result_d = stepResult;
                        state_d  = DONE;
                    end
                end
            end
            // DONE never re-checks start, so the op still sitting in E is not reissued.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= (state_d == BUSY);
            done_q   <= (state_d == DONE);
        end
    end

    // A flush seen in BUSY releases the stall in that same cycle.
    assign bus.stall  = rst && (start || ((state_q == BUSY) && !bus.flushE));
    assign bus.mc_sel = rst && (state_q == DONE);
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_multicycle_ctrl
// Self-checking bench for ex_multicycle_ctrl: directed cases followed by
// random MUL/DIV/REM(/MULH) operations compared against an arithmetic model
// of result value and cycle timing. Honours MULH_EN like the design.
// ---------------------------------------------------------------------------
module tb_ex_multicycle_ctrl;

    localparam logic [4:0] OP_MUL  = 5'b01010;
    localparam logic [4:0] OP_DIV  = 5'b01011;
    localparam logic [4:0] OP_REM  = 5'b01100;
    localparam logic [4:0] OP_MULH = 5'b01101;
    localparam logic [4:0] OP_ADD  = 5'b00000;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [18:0] prevRes;

    ex_multicycle_ctrl_if #(.WIDTH(19)) bus ();

    ex_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of E-stage inputs.
    task automatic applyStimulus(input logic v, input logic [4:0] op,
                                 input logic [18:0] a, input logic [18:0] b,
                                 input logic f);
        bus.validE      = v;
        bus.alucontrolE = op;
        bus.srcA        = a;
        bus.srcB        = b;
        bus.flushE      = f;
    endtask

    // Compare one observed value with the model's expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Run one instruction through E, checking every cycle until it retires.
    // flushAt: cycle offset from the start cycle at which flushE pulses (-1 none).
    task automatic runOp(input logic [4:0] op, input logic [18:0] a,
                         input logic [18:0] b, input int flushAt);
        bit              mc;
        bit              dz;
        bit              f;
        int              lat;
        logic [18:0]     res;
        longint unsigned prod;

        mc = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`ifdef MULH_EN
        mc = mc || (op == OP_MULH);
`endif
        if (!mc || flushAt == 0) begin
            applyStimulus(1'b1, op, a, b, flushAt == 0);
            #1;
            checkOutput("noStartStall", 32'(bus.stall), 32'd0);
            checkOutput("noStartMcSel", 32'(bus.mc_sel), 32'd0);
            @(negedge clk);
            applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
            #1;
            checkOutput("noStartBusy", 32'(bus.busy), 32'd0);
            checkOutput("noStartDone", 32'(bus.done), 32'd0);
            checkOutput("noStartResult", 32'(bus.result), 32'(prevRes));
            @(negedge clk);
            return;
        end

        prod = longint'(a) * longint'(b);
        dz   = ((op == OP_DIV) || (op == OP_REM)) && (b == 0);
        case (op)
            OP_MUL:  res = prod[18:0];
            OP_MULH: res = prod[37:19];
            OP_DIV:  res = dz ? 19'h7FFFF : a / b;
            default: res = dz ? a : a % b;
        endcase
        lat = dz ? 1 : 20;

        for (int k = 0; k <= lat; k++) begin
            f = (k == flushAt);
            applyStimulus(1'b1, op, a, b, f);
            #1;
            checkOutput($sformatf("stall op=%0d k=%0d", op, k), 32'(bus.stall),
                        32'((k < lat) && !f));
            checkOutput($sformatf("busy op=%0d k=%0d", op, k), 32'(bus.busy),
                        32'(!dz && k >= 1 && k <= 19));
            checkOutput($sformatf("done op=%0d k=%0d", op, k), 32'(bus.done), 32'(k == lat));
            checkOutput($sformatf("mcSel op=%0d k=%0d", op, k), 32'(bus.mc_sel), 32'(k == lat));
            checkOutput($sformatf("result op=%0d a=%0d b=%0d k=%0d", op, a, b, k),
                        32'(bus.result), (k == lat) ? 32'(res) : 32'(prevRes));
            @(negedge clk);
            if (f) begin
                for (int j = 0; j < 3; j++) begin
                    applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
                    #1;
                    checkOutput("flushBusy", 32'(bus.busy), 32'd0);
                    checkOutput("flushDone", 32'(bus.done), 32'd0);
                    checkOutput("flushStall", 32'(bus.stall), 32'd0);
                    checkOutput("flushResult", 32'(bus.result), 32'(prevRes));
                    @(negedge clk);
                end
                return;
            end
        end
        prevRes = res;
    endtask

    initial begin
        logic [4:0]  op;
        logic [18:0] a;
        logic [18:0] b;
        int          mode;

        total   = 0;
        bad     = 0;
        prevRes = '0;
        rst     = 1'b0;
        applyStimulus(1'b1, OP_MUL, 19'd5, 19'd6, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("resetStall", 32'(bus.stall), 32'd0);
        checkOutput("resetMcSel", 32'(bus.mc_sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
        #1;
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetDone", 32'(bus.done), 32'd0);
        checkOutput("resetResult", 32'(bus.result), 32'd0);
        @(negedge clk);

        // Directed cases.
        runOp(OP_MUL, 19'd123, 19'd45, -1);
        runOp(OP_MUL, 19'd1000, 19'd1000, -1);
        runOp(OP_MULH, 19'd1000, 19'd1000, -1);
        runOp(OP_DIV, 19'd1000, 19'd7, -1);
        runOp(OP_REM, 19'd1000, 19'd7, -1);
        runOp(OP_DIV, 19'd50, 19'd0, -1);
        runOp(OP_REM, 19'd50, 19'd0, -1);
        runOp(OP_MUL, 19'd3, 19'd4, 5);
        runOp(OP_DIV, 19'd9, 19'd2, 0);
        runOp(OP_ADD, 19'd9, 19'd2, -1);
        runOp(OP_MUL, 19'h7FFFF, 19'h7FFFF, -1);
        runOp(OP_DIV, 19'd5, 19'd9, -1);

        // Reset in the middle of a divide.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, OP_DIV, 19'd1000, 19'd7, 1'b0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checkOutput("midResetStall", 32'(bus.stall), 32'd0);
        checkOutput("midResetMcSel", 32'(bus.mc_sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        prevRes = '0;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, OP_DIV, 19'd1000, 19'd7, 1'b0);
            #1;
            checkOutput("postResetBusy", 32'(bus.busy), 32'd0);
            checkOutput("postResetDone", 32'(bus.done), 32'd0);
            checkOutput("postResetResult", 32'(bus.result), 32'd0);
            checkOutput("postResetStall", 32'(bus.stall), 32'd0);
            @(negedge clk);
        end

        // Random back-to-back operations.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_MUL;
                1:       op = OP_DIV;
                2:       op = OP_REM;
                default: op = OP_MULH;
            endcase
            a    = 19'($urandom_range(0, 524287));
            mode = int'($urandom_range(0, 7));
            if (mode == 0) begin
                b = '0;
            end else if (mode < 3) begin
                b = 19'($urandom_range(1, 20));
            end else begin
                b = 19'($urandom_range(0, 524287));
            end
            runOp(op, a, b, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 19)) : -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
